// File: rtl/mem_arb_pkg.sv
// Shared types for the two-master memory port arbiter: FSM state encoding and master index.
package mem_arb_pkg;

   localparam int MIDX_WDTH  = 1;
   localparam int STATE_WDTH = 3;

   typedef logic [MIDX_WDTH-1:0] midx_t;

   typedef enum logic [STATE_WDTH-1:0] {
      ST_IDLE         = 3'd0,
      ST_RD_ADDR      = 3'd1,
      ST_RD_DATA      = 3'd2,
      ST_WR_ADDR_DATA = 3'd3,
      ST_WR_RESP      = 3'd4,
      ST_RSP          = 3'd5
   } state_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester-side word request/response port and the five-channel memory port.
interface mem_req_if #(
   parameter int ADDR_WDTH = 4,
   parameter int DATA_WDTH = 32
);
   logic                 req_valid;
   logic                 req_ready;
   logic                 req_we;
   logic [ADDR_WDTH-1:0] req_addr;
   logic [DATA_WDTH-1:0] req_wdata;
   logic                 rsp_valid;
   logic                 rsp_ready;
   logic [DATA_WDTH-1:0] rsp_rdata;
   logic                 rsp_err;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

interface mem_axil_if #(
   parameter int ADDR_WDTH = 4,
   parameter int DATA_WDTH = 32,
   parameter int RESP_WDTH = 1
);
   logic                 ar_valid;
   logic                 ar_ready;
   logic [ADDR_WDTH-1:0] ar_addr;
   logic                 r_valid;
   logic                 r_ready;
   logic [DATA_WDTH-1:0] r_data;
   logic                 aw_valid;
   logic                 aw_ready;
   logic [ADDR_WDTH-1:0] aw_addr;
   logic                 w_valid;
   logic                 w_ready;
   logic [DATA_WDTH-1:0] w_data;
   logic                 b_valid;
   logic                 b_ready;
   logic [RESP_WDTH-1:0] b_resp;

   modport master (
      output ar_valid, ar_addr, r_ready, aw_valid, aw_addr, w_valid, w_data, b_ready,
      input  ar_ready, r_valid, r_data, aw_ready, w_ready, b_valid, b_resp
   );

   modport slave (
      input  ar_valid, ar_addr, r_ready, aw_valid, aw_addr, w_valid, w_data, b_ready,
      output ar_ready, r_valid, r_data, aw_ready, w_ready, b_valid, b_resp
   );
endinterface

// File: rtl/mem_rr_arbiter.sv
// Two-way round-robin grant: a sole requester wins, a tie goes to the master other than last_grant.
// Purely combinational; grant is zero whenever enable is low.
module mem_rr_arbiter
   import mem_arb_pkg::*;
(
   input  logic [1:0] req,
   input  midx_t      last_grant,
   input  logic       enable,
   output logic [1:0] grant,
   output midx_t      idx
);

   always_comb begin
      idx   = '0;
      grant = '0;
      if (enable && (req != 2'b00)) begin
         if (req == 2'b11) begin
            idx = ~last_grant;
         end else begin
            idx = midx_t'(req[1]);
         end
         grant = (idx == midx_t'(1)) ? 2'b10 : 2'b01;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises word requests from two masters onto one AR/R/AW/W/B memory port, one transaction at a time.
// Latency accept->rsp_valid is 3 cycles with an always-ready memory; only req_ready is combinational.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_WDTH = 4,
   parameter int DATA_WDTH = 32
) (
   input logic         clk,
   input logic         rst,
   mem_req_if.slave    m0,
   mem_req_if.slave    m1,
   mem_axil_if.master  mem
);

   state_t               state;
   midx_t                last_grant;
   midx_t                gnt;
   midx_t                arb_idx;
   logic [1:0]           arb_grant;
   logic [1:0]           req_vec;

   logic                 we_q;
   logic [ADDR_WDTH-1:0] addr_q;
   logic [DATA_WDTH-1:0] wdata_q;
   logic [DATA_WDTH-1:0] rdata_q;
   logic                 err_q;
   logic                 aw_done;
   logic                 w_done;

   logic                 ar_vld_q;
   logic                 r_rdy_q;
   logic                 aw_vld_q;
   logic                 w_vld_q;
   logic                 b_rdy_q;
   logic [1:0]           rsp_vld_q;

   logic                 sel_we;
   logic [ADDR_WDTH-1:0] sel_addr;
   logic [DATA_WDTH-1:0] sel_wdata;
   logic                 sel_rsp_ready;
   logic                 aw_hs;
   logic                 w_hs;
   logic                 aw_fin;
   logic                 w_fin;

   assign req_vec = {m1.req_valid, m0.req_valid};

   mem_rr_arbiter u_rr (
      .req        (req_vec),
      .last_grant (last_grant),
      .enable     (state == ST_IDLE),
      .grant      (arb_grant),
      .idx        (arb_idx)
   );

   assign m0.req_ready = arb_grant[0];
   assign m1.req_ready = arb_grant[1];

   always_comb begin
      sel_we        = m0.req_we;
      sel_addr      = m0.req_addr;
      sel_wdata     = m0.req_wdata;
      sel_rsp_ready = m0.rsp_ready;
      if (arb_idx == midx_t'(1)) begin
         sel_we    = m1.req_we;
         sel_addr  = m1.req_addr;
         sel_wdata = m1.req_wdata;
      end
      if (gnt == midx_t'(1)) begin
         sel_rsp_ready = m1.rsp_ready;
      end
   end

   // A done flag or a handshake in this very cycle both count as "finished".
   assign aw_hs  = aw_vld_q & mem.aw_ready;
   assign w_hs   = w_vld_q & mem.w_ready;
   assign aw_fin = aw_done | aw_hs;
   assign w_fin  = w_done | w_hs;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         last_grant <= midx_t'(1);
         gnt        <= '0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         rdata_q    <= '0;
         err_q      <= 1'b0;
         aw_done    <= 1'b0;
         w_done     <= 1'b0;
         ar_vld_q   <= 1'b0;
         r_rdy_q    <= 1'b0;
         aw_vld_q   <= 1'b0;
         w_vld_q    <= 1'b0;
         b_rdy_q    <= 1'b0;
         rsp_vld_q  <= 2'b00;
      end else begin
         case (state)
            ST_IDLE: begin
               if (arb_grant != 2'b00) begin
                  gnt     <= arb_idx;
                  we_q    <= sel_we;
                  addr_q  <= sel_addr;
                  wdata_q <= sel_wdata;
                  if (sel_we) begin
                     aw_vld_q <= 1'b1;
                     w_vld_q  <= 1'b1;
                     state    <= ST_WR_ADDR_DATA;
                  end else begin
                     ar_vld_q <= 1'b1;
                     state    <= ST_RD_ADDR;
                  end
               end
            end

            ST_RD_ADDR: begin
               if (mem.ar_ready) begin
                  ar_vld_q <= 1'b0;
                  r_rdy_q  <= 1'b1;
                  state    <= ST_RD_DATA;
               end
            end

            ST_RD_DATA: begin
               if (mem.r_valid) begin
                  rdata_q        <= mem.r_data;
                  err_q          <= 1'b0;
                  r_rdy_q        <= 1'b0;
                  rsp_vld_q[gnt] <= 1'b1;
                  state          <= ST_RSP;
               end
            end

            ST_WR_ADDR_DATA: begin
               if (aw_hs) begin
                  aw_vld_q <= 1'b0;
                  aw_done  <= 1'b1;
               end
               if (w_hs) begin
                  w_vld_q <= 1'b0;
                  w_done  <= 1'b1;
               end
               if (aw_fin && w_fin) begin
                  aw_done <= 1'b0;
                  w_done  <= 1'b0;
                  b_rdy_q <= 1'b1;
                  state   <= ST_WR_RESP;
               end
            end

            ST_WR_RESP: begin
               if (mem.b_valid) begin
                  err_q          <= |mem.b_resp;
                  rdata_q        <= '0;
                  b_rdy_q        <= 1'b0;
                  rsp_vld_q[gnt] <= 1'b1;
                  state          <= ST_RSP;
               end
            end

            ST_RSP: begin
               if (sel_rsp_ready) begin
                  rsp_vld_q  <= 2'b00;
                  last_grant <= gnt;
                  state      <= ST_IDLE;
               end
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

   assign mem.ar_valid = ar_vld_q;
   assign mem.ar_addr  = addr_q;
   assign mem.r_ready  = r_rdy_q;
   assign mem.aw_valid = aw_vld_q;
   assign mem.aw_addr  = addr_q;
   assign mem.w_valid  = w_vld_q;
   assign mem.w_data   = wdata_q;
   assign mem.b_ready  = b_rdy_q;

   // Response payload is only visible to the master whose response is pending.
   assign m0.rsp_valid = rsp_vld_q[0];
   assign m0.rsp_rdata = rsp_vld_q[0] ? rdata_q : '0;
   assign m0.rsp_err   = rsp_vld_q[0] & err_q;
   assign m1.rsp_valid = rsp_vld_q[1];
   assign m1.rsp_rdata = rsp_vld_q[1] ? rdata_q : '0;
   assign m1.rsp_err   = rsp_vld_q[1] & err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: single reads/writes, round-robin ties, response stall, mid-transaction reset.
module tb_mem_port_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mem_req_if  #(.ADDR_WDTH(4), .DATA_WDTH(32))                m0_if ();
   mem_req_if  #(.ADDR_WDTH(4), .DATA_WDTH(32))                m1_if ();
   mem_axil_if #(.ADDR_WDTH(4), .DATA_WDTH(32), .RESP_WDTH(1)) mem_if ();

   mem_port_arbiter #(.ADDR_WDTH(4), .DATA_WDTH(32)) dut (
      .clk (clk),
      .rst (rst),
      .m0  (m0_if),
      .m1  (m1_if),
      .mem (mem_if)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   function automatic logic [31:0] hs_bits();
      return {23'd0, mem_if.ar_valid, mem_if.r_ready, mem_if.aw_valid, mem_if.w_valid,
              mem_if.b_ready, m0_if.rsp_valid, m1_if.rsp_valid, m0_if.req_ready, m1_if.req_ready};
   endfunction

   initial begin
      m0_if.req_valid = 1'b0; m0_if.req_we = 1'b0; m0_if.req_addr = '0; m0_if.req_wdata = '0;
      m0_if.rsp_ready = 1'b1;
      m1_if.req_valid = 1'b0; m1_if.req_we = 1'b0; m1_if.req_addr = '0; m1_if.req_wdata = '0;
      m1_if.rsp_ready = 1'b1;
      mem_if.ar_ready = 1'b1; mem_if.r_valid = 1'b1; mem_if.r_data = 32'hDEADBEEF;
      mem_if.aw_ready = 1'b1; mem_if.w_ready = 1'b1; mem_if.b_valid = 1'b1; mem_if.b_resp = 1'b0;

      rst = 1'b1;
      repeat (2) step();
      rst = 1'b0;
      step(); #1;
      chk("rst_handshakes", hs_bits(), 32'd0);
      chk("rst_ar_addr", 32'(mem_if.ar_addr), 32'd0);
      chk("rst_w_data", mem_if.w_data, 32'd0);
      chk("rst_m0_rdata", m0_if.rsp_rdata, 32'd0);

      // Read from m0, memory always ready.
      m0_if.req_valid = 1'b1; m0_if.req_we = 1'b0; m0_if.req_addr = 4'd3; #1;
      chk("t1_m0_ready_c0", 32'(m0_if.req_ready), 32'd1);
      chk("t1_m1_ready_c0", 32'(m1_if.req_ready), 32'd0);
      step(); m0_if.req_valid = 1'b0; #1;
      chk("t1_ar_valid_c1", 32'(mem_if.ar_valid), 32'd1);
      chk("t1_ar_addr_c1", 32'(mem_if.ar_addr), 32'd3);
      step(); #1;
      chk("t1_r_ready_c2", 32'(mem_if.r_ready), 32'd1);
      chk("t1_ar_valid_c2", 32'(mem_if.ar_valid), 32'd0);
      step(); #1;
      chk("t1_rsp_valid_c3", 32'(m0_if.rsp_valid), 32'd1);
      chk("t1_rdata_c3", m0_if.rsp_rdata, 32'hDEADBEEF);
      chk("t1_err_c3", 32'(m0_if.rsp_err), 32'd0);
      chk("t1_m1_rsp_valid", 32'(m1_if.rsp_valid), 32'd0);
      chk("t1_m1_rdata", m1_if.rsp_rdata, 32'd0);
      step(); #1;
      chk("t1_rsp_done", 32'(m0_if.rsp_valid), 32'd0);

      // Write from m1 with aw accepted at once and w held off until c4, error response.
      mem_if.w_ready = 1'b0; mem_if.b_resp = 1'b1;
      m1_if.req_valid = 1'b1; m1_if.req_we = 1'b1; m1_if.req_addr = 4'd5; m1_if.req_wdata = 32'h12; #1;
      chk("t2_m1_ready_c0", 32'(m1_if.req_ready), 32'd1);
      step(); m1_if.req_valid = 1'b0; #1;
      chk("t2_aw_valid_c1", 32'(mem_if.aw_valid), 32'd1);
      chk("t2_w_valid_c1", 32'(mem_if.w_valid), 32'd1);
      chk("t2_aw_addr_c1", 32'(mem_if.aw_addr), 32'd5);
      chk("t2_w_data_c1", mem_if.w_data, 32'h12);
      step(); #1;
      chk("t2_aw_valid_c2", 32'(mem_if.aw_valid), 32'd0);
      chk("t2_w_valid_c2", 32'(mem_if.w_valid), 32'd1);
      step(); #1;
      chk("t2_w_valid_c3", 32'(mem_if.w_valid), 32'd1);
      chk("t2_b_ready_c3", 32'(mem_if.b_ready), 32'd0);
      step(); mem_if.w_ready = 1'b1; #1;
      chk("t2_w_valid_c4", 32'(mem_if.w_valid), 32'd1);
      chk("t2_w_data_c4", mem_if.w_data, 32'h12);
      step(); #1;
      chk("t2_w_valid_c5", 32'(mem_if.w_valid), 32'd0);
      chk("t2_b_ready_c5", 32'(mem_if.b_ready), 32'd1);
      step(); #1;
      chk("t2_rsp_valid", 32'(m1_if.rsp_valid), 32'd1);
      chk("t2_rsp_err", 32'(m1_if.rsp_err), 32'd1);
      chk("t2_rsp_rdata", m1_if.rsp_rdata, 32'd0);
      chk("t2_m0_rsp_valid", 32'(m0_if.rsp_valid), 32'd0);
      step(); mem_if.b_resp = 1'b0; #1;
      chk("t2_rsp_done", 32'(m1_if.rsp_valid), 32'd0);

      // Both masters request continuously: grants alternate starting with m0.
      m0_if.req_valid = 1'b1; m0_if.req_we = 1'b0; m0_if.req_addr = 4'd1;
      m1_if.req_valid = 1'b1; m1_if.req_we = 1'b0; m1_if.req_addr = 4'd2;
      for (int t = 0; t < 4; t++) begin
         mem_if.r_data = 32'hA0 + 32'(t); #1;
         chk($sformatf("t3_m0_ready_%0d", t), 32'(m0_if.req_ready), 32'((t % 2) == 0));
         chk($sformatf("t3_m1_ready_%0d", t), 32'(m1_if.req_ready), 32'((t % 2) == 1));
         step(); #1;
         chk($sformatf("t3_ar_addr_%0d", t), 32'(mem_if.ar_addr), ((t % 2) == 0) ? 32'd1 : 32'd2);
         chk($sformatf("t3_busy_ready_%0d", t), 32'(m0_if.req_ready | m1_if.req_ready), 32'd0);
         step();
         step(); #1;
         if ((t % 2) == 0) begin
            chk($sformatf("t3_rsp_m0_%0d", t), 32'(m0_if.rsp_valid), 32'd1);
            chk($sformatf("t3_rdata_m0_%0d", t), m0_if.rsp_rdata, 32'hA0 + 32'(t));
         end else begin
            chk($sformatf("t3_rsp_m1_%0d", t), 32'(m1_if.rsp_valid), 32'd1);
            chk($sformatf("t3_rdata_m1_%0d", t), m1_if.rsp_rdata, 32'hA0 + 32'(t));
         end
         step();
      end

      // m0 stalls its response for 5 cycles while m1 waits.
      m1_if.req_valid = 1'b0;
      m0_if.req_addr = 4'd7; m0_if.rsp_ready = 1'b0; mem_if.r_data = 32'h55AA; #1;
      chk("t4_m0_ready_c0", 32'(m0_if.req_ready), 32'd1);
      step(); m0_if.req_valid = 1'b0; m1_if.req_valid = 1'b1; m1_if.req_addr = 4'd6; #1;
      chk("t4_m1_wait_c1", 32'(m1_if.req_ready), 32'd0);
      step();
      step(); mem_if.r_data = 32'hFFFF;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk($sformatf("t4_hold_valid_%0d", i), 32'(m0_if.rsp_valid), 32'd1);
         chk($sformatf("t4_hold_rdata_%0d", i), m0_if.rsp_rdata, 32'h55AA);
         chk($sformatf("t4_hold_m1_%0d", i), 32'(m1_if.req_ready), 32'd0);
         step();
      end
      m0_if.rsp_ready = 1'b1; #1;
      chk("t4_rsp_hs_valid", 32'(m0_if.rsp_valid), 32'd1);
      chk("t4_no_accept_with_rsp", 32'(m1_if.req_ready), 32'd0);
      step(); mem_if.r_data = 32'h66; #1;
      chk("t4_m0_rsp_done", 32'(m0_if.rsp_valid), 32'd0);
      chk("t4_m1_accept", 32'(m1_if.req_ready), 32'd1);
      step(); m1_if.req_valid = 1'b0;
      step();
      step(); #1;
      chk("t4_m1_rsp_valid", 32'(m1_if.rsp_valid), 32'd1);
      chk("t4_m1_rdata", m1_if.rsp_rdata, 32'h66);
      step();

      // Reset while waiting for read data.
      mem_if.r_valid = 1'b0;
      m0_if.req_valid = 1'b1; m0_if.req_addr = 4'd9; #1;
      chk("t5_m0_ready_c0", 32'(m0_if.req_ready), 32'd1);
      step(); m0_if.req_valid = 1'b0; #1;
      chk("t5_ar_valid_c1", 32'(mem_if.ar_valid), 32'd1);
      step(); #1;
      chk("t5_r_ready_c2", 32'(mem_if.r_ready), 32'd1);
      rst = 1'b1;
      step(); rst = 1'b0; #1;
      chk("t5_handshakes", hs_bits(), 32'd0);
      chk("t5_ar_addr", 32'(mem_if.ar_addr), 32'd0);
      chk("t5_w_data", mem_if.w_data, 32'd0);
      chk("t5_state_idle", 32'(dut.state), 32'd0);
      mem_if.r_valid = 1'b1; mem_if.r_data = 32'h77;
      m1_if.req_valid = 1'b1; m1_if.req_addr = 4'd4; #1;
      chk("t5_m1_ready", 32'(m1_if.req_ready), 32'd1);
      step(); m1_if.req_valid = 1'b0; #1;
      chk("t5_m1_ar_addr", 32'(mem_if.ar_addr), 32'd4);
      step();
      step(); #1;
      chk("t5_m1_rsp_valid", 32'(m1_if.rsp_valid), 32'd1);
      chk("t5_m1_rdata", m1_if.rsp_rdata, 32'h77);
      chk("t5_m1_err", 32'(m1_if.rsp_err), 32'd0);
      step();
      m0_if.req_valid = 1'b1; m1_if.req_valid = 1'b1; #1;
      chk("t5_tie_m0", 32'(m0_if.req_ready), 32'd1);
      chk("t5_tie_m1", 32'(m1_if.req_ready), 32'd0);
      step(); m0_if.req_valid = 1'b0; m1_if.req_valid = 1'b0;
      repeat (4) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
